// File: rtl/dcache_direct_if.sv
// CPU-side and datamemory-side signals of the direct-mapped data cache.
// The cache connects through the slave modport; the CPU/memory environment uses master.
interface dcache_direct_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
);
    logic                                    cpu_req;
    logic                                    cpu_we;
    logic [ADDRESS_WIDTH-1:0]                cpu_address;
    logic [DATA_WIDTH-1:0]                   cpu_write_data;
    logic [DATA_WIDTH-1:0]                   cpu_read_data;
    logic                                    cpu_stall;
    logic [ADDRESS_WIDTH-1:0]                mem_address;
    logic [DATA_WIDTH-1:0]                   mem_write_data;
    logic                                    mem_write_enable;
    logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0]   mem_read_data;

    modport master (
        output cpu_req, cpu_we, cpu_address, cpu_write_data, mem_read_data,
        input  cpu_read_data, cpu_stall, mem_address, mem_write_data, mem_write_enable
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_address, cpu_write_data, mem_read_data,
        output cpu_read_data, cpu_stall, mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Load hits return data combinationally; load misses fill a whole line from the block-wide memory port.
module dcache_direct #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3,
    parameter int INDEX_BITS    = 4,
    parameter int FILL_LATENCY  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_direct_if.slave       bus,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);
    localparam int WORDS    = 1 << BLOCK_SIZE;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - BLOCK_SIZE;
    localparam int CNT_W    = (FILL_LATENCY > 1) ? $clog2(FILL_LATENCY) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]            state_reg;
    logic [0:0]            state_next;
    logic [CNT_W-1:0]      fill_cnt_reg;
    logic                  prev_fill_reg;
    logic [LINES-1:0]      valid_reg;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES][WORDS];
    logic [DATA_WIDTH-1:0] fill_words [WORDS];

    logic [BLOCK_SIZE-1:0]    req_offset;
    logic [INDEX_BITS-1:0]    req_index;
    logic [TAG_BITS-1:0]      req_tag;
    logic [ADDRESS_WIDTH-1:0] line_address;

    logic in_idle;
    logic in_fill;
    logic hit;
    logic load_hit;
    logic load_miss;
    logic store;
    logic fill_done;

    assign req_offset   = bus.cpu_address[BLOCK_SIZE-1:0];
    assign req_index    = bus.cpu_address[BLOCK_SIZE+INDEX_BITS-1:BLOCK_SIZE];
    assign req_tag      = bus.cpu_address[ADDRESS_WIDTH-1:BLOCK_SIZE+INDEX_BITS];
    assign line_address = {bus.cpu_address[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};

    // Unpack the block-wide memory read port into per-word lanes.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_fill_word
            assign fill_words[gi] = bus.mem_read_data[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    assign in_idle   = (state_reg == IDLE);
    assign in_fill   = (state_reg == FILL);
    assign hit       = bus.cpu_req & valid_reg[req_index] & (tag_mem[req_index] == req_tag);
    assign load_hit  = in_idle & hit & ~bus.cpu_we;
    assign load_miss = in_idle & bus.cpu_req & ~bus.cpu_we & ~hit;
    assign store     = in_idle & bus.cpu_req & bus.cpu_we;
    assign fill_done = in_fill & (fill_cnt_reg == CNT_W'(FILL_LATENCY - 1));

    // The CPU holds its request through FILL, so the fill line address is rebuilt from it.
    assign bus.cpu_stall        = in_fill | load_miss;
    assign bus.cpu_read_data    = load_hit ? data_mem[req_index][req_offset] : '0;
    assign bus.mem_write_enable = store & rst_n;
    assign bus.mem_address      = store ? bus.cpu_address : line_address;
    assign bus.mem_write_data   = bus.cpu_write_data;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_miss) state_next = FILL;
            FILL:    if (fill_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fill_cnt_reg  <= '0;
            prev_fill_reg <= 1'b0;
            valid_reg     <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state_reg     <= state_next;
            prev_fill_reg <= in_fill;
            if (load_miss) begin
                fill_cnt_reg <= '0;
                miss_count   <= miss_count + 16'd1;
            end else if (in_fill) begin
                fill_cnt_reg <= fill_cnt_reg + CNT_W'(1);
            end
            // The held load completing right after a fill was already counted as a miss.
            if (load_hit && !prev_fill_reg) begin
                hit_count <= hit_count + 16'd1;
            end
            if (fill_done) begin
                valid_reg[req_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (fill_done) begin
                tag_mem[req_index] <= req_tag;
                for (int w = 0; w < WORDS; w++) begin
                    data_mem[req_index][w] <= fill_words[w];
                end
            end else if (store && hit) begin
                data_mem[req_index][req_offset] <= bus.cpu_write_data;
            end
        end
    end
endmodule
